// File: rtl/apu_frame_counter.sv
// APU frame sequencer: quarter/half-frame strobes, $4017 control register and frame IRQ.
// The sequencer advances only on apu_clk strobes; all outputs are registered.
module apu_frame_counter #(
    parameter int STEP1     = 7457,
    parameter int STEP2     = 14913,
    parameter int STEP3     = 22371,
    parameter int STEP4_4   = 29829,
    parameter int STEP5_5   = 37281,
    parameter int RST_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_clk,
    input  logic       frame_wr,
    input  logic [7:0] from_cpu,
    input  logic       status_rd,
    output logic       e_pulse,
    output logic       l_pulse,
    output logic       frame_irq
);

    localparam logic [15:0] S1       = 16'(STEP1);
    localparam logic [15:0] S2       = 16'(STEP2);
    localparam logic [15:0] S3       = 16'(STEP3);
    localparam logic [15:0] S4       = 16'(STEP4_4);
    localparam logic [15:0] S5       = 16'(STEP5_5);
    localparam logic [15:0] WRAP4    = 16'(STEP4_4 + 1);
    localparam logic [15:0] WRAP5    = 16'(STEP5_5 + 1);
    localparam logic [15:0] IRQ_EARLY = 16'(STEP4_4 - 1);
    localparam logic [1:0]  DLY_INIT = 2'(RST_DELAY - 1);

    logic [15:0] cycle_cnt;
    logic        mode;
    logic        irq_inhibit;
    logic        irq_flag;
    logic        rst_pending;
    logic [1:0]  rst_dly;

    logic [15:0] cnt_inc;
    logic [15:0] cnt_next;
    logic        wrap;
    logic        seq_rst;
    logic        quarter_p0;
    logic        half_p0;
    logic        irq_set;
    logic        unused_bits;

    assign unused_bits = ^from_cpu[5:0];

    // Stage p0: decode the value the counter is about to take
    always_comb begin
        cnt_inc    = cycle_cnt + 16'd1;
        wrap       = mode ? (cnt_inc == WRAP5) : (cnt_inc == WRAP4);
        cnt_next   = wrap ? 16'd0 : cnt_inc;
        // A write on the same clk restarts the delay instead of firing the old one
        seq_rst    = rst_pending && (rst_dly == 2'd0) && !frame_wr;
        quarter_p0 = (cnt_next == S1) || (cnt_next == S2) || (cnt_next == S3) ||
                     (!mode && (cnt_next == S4)) || (mode && (cnt_next == S5));
        half_p0    = (cnt_next == S2) ||
                     (!mode && (cnt_next == S4)) || (mode && (cnt_next == S5));
        irq_set    = !mode && !irq_inhibit &&
                     ((cnt_next == IRQ_EARLY) || (cnt_next == S4) || wrap);
    end

    // Stage p1: registered sequencer state and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt   <= 16'd0;
            mode        <= 1'b0;
            irq_inhibit <= 1'b0;
            irq_flag    <= 1'b0;
            rst_pending <= 1'b0;
            rst_dly     <= 2'd0;
            e_pulse     <= 1'b0;
            l_pulse     <= 1'b0;
        end else begin
            e_pulse <= 1'b0;
            l_pulse <= 1'b0;

            if (apu_clk) begin
                if (seq_rst) begin
                    cycle_cnt   <= 16'd0;
                    rst_pending <= 1'b0;
                    e_pulse     <= mode;
                    l_pulse     <= mode;
                end else begin
                    cycle_cnt <= cnt_next;
                    e_pulse   <= quarter_p0;
                    l_pulse   <= half_p0;
                    if (rst_pending) begin
                        rst_dly <= rst_dly - 2'd1;
                    end
                end
            end

            if (frame_wr) begin
                mode        <= from_cpu[7];
                irq_inhibit <= from_cpu[6];
                rst_pending <= 1'b1;
                rst_dly     <= DLY_INIT;
            end

            // Inhibit write clears unconditionally; otherwise a set beats a status read
            if (frame_wr && from_cpu[6]) begin
                irq_flag <= 1'b0;
            end else if (apu_clk && !seq_rst && irq_set) begin
                irq_flag <= 1'b1;
            end else if (status_rd) begin
                irq_flag <= 1'b0;
            end
        end
    end

    assign frame_irq = irq_flag;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Bench for apu_frame_counter: a default-parameter instance for one full 4-step frame,
// and a scaled-step instance for mode, IRQ, write-delay and async reset scenarios.
`timescale 1ns/1ps
module tb_apu_frame_counter;

    typedef struct {
        int   idx;
        logic e;
        logic l;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       apu_clk, frame_wr, status_rd;
    logic [7:0] from_cpu;
    logic       e_pulse, l_pulse, frame_irq;
    logic       d_apu_clk, d_frame_wr, d_status_rd;
    logic [7:0] d_from_cpu;
    logic       d_e, d_l, d_irq;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   sidx;
    logic irq_seen;
    ev_t  sb[$];

    always #5 clk = ~clk;

    apu_frame_counter #(
        .STEP1(7), .STEP2(15), .STEP3(23), .STEP4_4(31), .STEP5_5(39), .RST_DELAY(3)
    ) dut (
        .clk(clk), .rst(rst), .apu_clk(apu_clk), .frame_wr(frame_wr),
        .from_cpu(from_cpu), .status_rd(status_rd),
        .e_pulse(e_pulse), .l_pulse(l_pulse), .frame_irq(frame_irq)
    );

    apu_frame_counter dut_d (
        .clk(clk), .rst(rst), .apu_clk(d_apu_clk), .frame_wr(d_frame_wr),
        .from_cpu(d_from_cpu), .status_rd(d_status_rd),
        .e_pulse(d_e), .l_pulse(d_l), .frame_irq(d_irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int idx, input logic e, input logic l);
        sb.push_back(ev_t'{idx: idx, e: e, l: l});
    endtask

    task automatic score(input logic e, input logic l);
        ev_t x;
        if (sb.size() > 0 && sb[0].idx == sidx) begin
            x = sb.pop_front();
            check($sformatf("pulse@%0d", sidx), {30'd0, e, l}, {30'd0, x.e, x.l});
        end else if (e || l) begin
            check($sformatf("spurious@%0d", sidx), {30'd0, e, l}, 32'd0);
        end
    endtask

    task automatic strobe(input logic rd);
        @(negedge clk);
        apu_clk   = 1'b1;
        status_rd = rd;
        @(negedge clk);
        apu_clk   = 1'b0;
        status_rd = 1'b0;
        sidx++;
        irq_seen = irq_seen | frame_irq;
        score(e_pulse, l_pulse);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) strobe(1'b0);
    endtask

    task automatic ctl(input logic rd, input logic wr, input logic [7:0] d);
        @(negedge clk);
        status_rd = rd;
        frame_wr  = wr;
        from_cpu  = d;
        @(negedge clk);
        status_rd = 1'b0;
        frame_wr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        apu_clk = 0; frame_wr = 0; status_rd = 0; from_cpu = 8'h00;
        d_apu_clk = 0; d_frame_wr = 0; d_status_rd = 0; d_from_cpu = 8'h00;
        irq_seen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_e", {31'd0, e_pulse}, 32'd0);
        check("rst_l", {31'd0, l_pulse}, 32'd0);
        check("rst_irq", {31'd0, frame_irq}, 32'd0);
        check("rst_d_irq", {31'd0, d_irq}, 32'd0);

        // Default parameters, one complete 4-step frame with apu_clk every clk
        sidx = 0;
        push_ev(7457, 1, 0); push_ev(14913, 1, 1); push_ev(22371, 1, 0); push_ev(29829, 1, 1);
        @(negedge clk);
        d_apu_clk = 1'b1;
        for (int i = 1; i <= 29830; i++) begin
            @(negedge clk);
            sidx = i;
            score(d_e, d_l);
            if (i == 29827) check("d_irq_before", {31'd0, d_irq}, 32'd0);
            if (i == 29828) check("d_irq_set", {31'd0, d_irq}, 32'd1);
        end
        d_apu_clk = 1'b0;
        check("d_cnt_wrap", {16'd0, dut_d.cycle_cnt}, 32'd0);
        check("d_drain", sb.size(), 32'd0);

        // Mode 0 on the scaled instance with the set/clear race at count 31
        sidx = 0;
        push_ev(7, 1, 0); push_ev(15, 1, 1); push_ev(23, 1, 0); push_ev(31, 1, 1);
        run(29);
        check("irq_at29", {31'd0, frame_irq}, 32'd0);
        run(1);
        check("irq_at30", {31'd0, frame_irq}, 32'd1);
        strobe(1'b1);
        check("irq_race_set_wins", {31'd0, frame_irq}, 32'd1);
        run(1);
        check("cnt_wrap", {16'd0, dut.cycle_cnt}, 32'd0);
        ctl(1'b1, 1'b0, 8'h00);
        check("irq_read_clear", {31'd0, frame_irq}, 32'd0);
        check("m0_drain", sb.size(), 32'd0);

        // Inhibit write clears the flag, then a whole frame without a set
        sidx = 0;
        push_ev(7, 1, 0); push_ev(15, 1, 1); push_ev(23, 1, 0); push_ev(31, 1, 1);
        run(30);
        check("irq_before_inh", {31'd0, frame_irq}, 32'd1);
        ctl(1'b0, 1'b1, 8'h40);
        check("irq_inh_clear", {31'd0, frame_irq}, 32'd0);
        run(3);
        sidx = 0;
        irq_seen = 1'b0;
        push_ev(7, 1, 0); push_ev(15, 1, 1); push_ev(23, 1, 0); push_ev(31, 1, 1);
        run(32);
        check("inh_no_irq", {31'd0, irq_seen}, 32'd0);
        check("inh_drain", sb.size(), 32'd0);

        // Mode 1: immediate pulse after the delay, then two 5-step frames
        ctl(1'b0, 1'b1, 8'h80);
        sidx = 0;
        irq_seen = 1'b0;
        push_ev(3, 1, 1);
        push_ev(10, 1, 0); push_ev(18, 1, 1); push_ev(26, 1, 0); push_ev(42, 1, 1);
        push_ev(50, 1, 0); push_ev(58, 1, 1); push_ev(66, 1, 0); push_ev(82, 1, 1);
        run(83);
        check("m1_no_irq", {31'd0, irq_seen}, 32'd0);
        check("m1_drain", sb.size(), 32'd0);

        // Back-to-back writes: only the second write's deadline resets
        ctl(1'b0, 1'b1, 8'h00);
        run(1);
        ctl(1'b0, 1'b1, 8'h80);
        sidx = 0;
        push_ev(3, 1, 1); push_ev(10, 1, 0); push_ev(18, 1, 1);
        run(18);
        check("b2b_drain", sb.size(), 32'd0);

        // Async reset mid-frame with the flag set and a write in flight
        ctl(1'b0, 1'b1, 8'h00);
        sidx = 0;
        push_ev(10, 1, 0); push_ev(18, 1, 1); push_ev(26, 1, 0); push_ev(34, 1, 1);
        run(33);
        check("pre_rst_irq_set", {31'd0, frame_irq}, 32'd1);
        run(8);
        ctl(1'b0, 1'b1, 8'h80);
        push_ev(42, 1, 0);
        run(1);
        check("pre_rst_irq", {31'd0, frame_irq}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_e", {31'd0, e_pulse}, 32'd0);
        check("arst_l", {31'd0, l_pulse}, 32'd0);
        check("arst_irq", {31'd0, frame_irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("arst_drain", sb.size(), 32'd0);
        sidx = 0;
        push_ev(7, 1, 0); push_ev(15, 1, 1); push_ev(23, 1, 0); push_ev(31, 1, 1);
        run(30);
        check("post_rst_irq", {31'd0, frame_irq}, 32'd1);
        run(1);
        check("post_rst_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
